// File: rtl/l0_sched_if.sv
// Handshake and address bundle between the layer-0 sequencer and its neighbours
// (image buffer, window registers, convolution engine).
interface l0_sched_if #(
  parameter int AW = 10
);
  logic          frm_vld;
  logic          frm_rdy;
  logic          ds_rdy;
  logic          win_ld;
  logic [AW-1:0] img_addr;
  logic          l0_strt;
  logic          l0_addr_inc;
  logic          l0_rd;
  logic          l0_tx_done;
  logic          busy;
  logic [AW-1:0] win_cnt;
  logic          err;

  modport master (
    output frm_vld, ds_rdy, l0_addr_inc, l0_rd,
    input  frm_rdy, win_ld, img_addr, l0_strt, l0_tx_done, busy, win_cnt, err
  );

  modport slave (
    input  frm_vld, ds_rdy, l0_addr_inc, l0_rd,
    output frm_rdy, win_ld, img_addr, l0_strt, l0_tx_done, busy, win_cnt, err
  );
endinterface

// File: rtl/l0_sched.sv
// Layer-0 frame sequencer: walks the KxK window over the image in raster order.
// Optional watchdog on WAIT/DRAIN enabled by defining L0_SCHED_WDOG_EN.
module l0_sched #(
  parameter int IMG_W   = 28,
  parameter int IMG_H   = 28,
  parameter int K       = 3,
  parameter int WIN_LAT = 2,
  parameter int AW      = 10
) (
  input  logic       clk,
  input  logic       rst,
  l0_sched_if.slave  bus
);

  localparam int            LW       = (WIN_LAT < 1) ? 1 : $clog2(WIN_LAT + 1);
  localparam logic [AW-1:0] COL_LAST = AW'(IMG_W - K);
  localparam logic [AW-1:0] ROW_LAST = AW'(IMG_H - K);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_STRT, S_WAIT, S_ADV, S_DRAIN, S_DONE
  } state_t;

  state_t        r_state, w_state_next;
  logic [LW-1:0] r_lat;
  logic          r_rd_low;
  logic [AW-1:0] r_img_addr;
  logic [AW-1:0] r_row;
  logic [AW-1:0] r_col;
  logic [AW-1:0] r_win_cnt;
  logic          r_err;
  logic          w_last;
  logic          w_stray;
`ifdef L0_SCHED_WDOG_EN
  logic [4:0]    r_wdog;
  logic          w_abort;
`endif

  assign w_last  = (r_row == ROW_LAST) && (r_col == COL_LAST);
  assign w_stray = bus.l0_addr_inc && (r_state != S_WAIT);

  always_comb begin
    w_state_next = r_state;
`ifdef L0_SCHED_WDOG_EN
    w_abort      = 1'b0;
`endif
    case (r_state)
      S_IDLE:  if (bus.frm_vld) w_state_next = S_LOAD;
      S_LOAD:  if (r_lat == LW'(WIN_LAT)) w_state_next = S_STRT;
      S_STRT:  if (bus.ds_rdy) w_state_next = S_WAIT;
      S_WAIT:  if (bus.l0_addr_inc) w_state_next = S_ADV;
      S_ADV:   w_state_next = w_last ? S_DRAIN : S_LOAD;
      // r_rd_low remembers that l0_rd was low on the previous DRAIN cycle
      S_DRAIN: if (!bus.l0_rd && r_rd_low) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
`ifdef L0_SCHED_WDOG_EN
    if ((r_state == S_WAIT || r_state == S_DRAIN) && (w_state_next == r_state)
        && (r_wdog == 5'd31)) begin
      w_state_next = S_DONE;
      w_abort      = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_lat      <= '0;
      r_rd_low   <= 1'b0;
      r_img_addr <= '0;
      r_row      <= '0;
      r_col      <= '0;
      r_win_cnt  <= '0;
      r_err      <= 1'b0;
`ifdef L0_SCHED_WDOG_EN
      r_wdog     <= '0;
`endif
    end else begin
      r_state  <= w_state_next;
      r_lat    <= (r_state == S_LOAD) ? r_lat + 1'b1 : '0;
      r_rd_low <= (r_state == S_DRAIN) && !bus.l0_rd;
`ifdef L0_SCHED_WDOG_EN
      r_wdog   <= (r_state == S_WAIT || r_state == S_DRAIN) ? r_wdog + 1'b1 : '0;
`endif
      case (r_state)
        S_IDLE: if (bus.frm_vld) begin
          r_img_addr <= '0;
          r_row      <= '0;
          r_col      <= '0;
          r_win_cnt  <= '0;
          r_err      <= 1'b0;
        end
        S_WAIT: if (bus.l0_addr_inc) r_win_cnt <= r_win_cnt + 1'b1;
        S_ADV: begin
          if (r_col < COL_LAST) begin
            r_col      <= r_col + 1'b1;
            r_img_addr <= r_img_addr + 1'b1;
          end else begin
            // wrap to next row: jump over the K-1 right-border pixels
            r_col      <= '0;
            r_row      <= r_row + 1'b1;
            r_img_addr <= r_img_addr + AW'(K);
          end
        end
        default: ;
      endcase
      if (w_stray) r_err <= 1'b1;
`ifdef L0_SCHED_WDOG_EN
      if (w_abort) r_err <= 1'b1;
`endif
    end
  end

  assign bus.frm_rdy    = (r_state == S_IDLE);
  assign bus.busy       = (r_state != S_IDLE);
  assign bus.win_ld     = (r_state == S_LOAD) && (r_lat == '0);
  assign bus.l0_strt    = (r_state == S_STRT) && bus.ds_rdy;
  assign bus.l0_tx_done = (r_state == S_DONE);
  assign bus.img_addr   = r_img_addr;
  assign bus.win_cnt    = r_win_cnt;
  assign bus.err        = r_err;

endmodule

// File: doc/l0_sched.md
Name: l0_sched

Overview:
- Frame-level sequencer for the layer-0 convolution engine.
- Accepts a "frame ready" handshake from the input image buffer and walks the 3x3 window across the image in raster order.
- For each window position, drives the window-buffer load address, pulses the engine start and waits for the engine's per-window completion pulse.
- After the last window, waits for the pooled readout to drain, then issues the frame-clear pulse that rewinds the engine's RAM pointers.

Parameters:
- IMG_W, 28, image width in pixels.
- IMG_H, 28, image height in pixels.
- K, 3, kernel edge; output grid is (IMG_W-K+1) x (IMG_H-K+1), 26x26 by default.
- WIN_LAT, 2, cycles from win_ld to window registers valid.
- AW, 10, image address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- frm_vld  in  1  input frame resident in image buffer.
- frm_rdy  out  1  sequencer can accept a frame; frame accepted on frm_vld&frm_rdy.
- ds_rdy  in  1  downstream can accept more layer-0 results; gates new window starts.
- win_ld  out  1  load 3x3 window at img_addr into window registers.
- img_addr  out  AW  top-left pixel address of current window, row*IMG_W+col.
- l0_strt  out  1  one-cycle engine start.
- l0_addr_inc  in  1  engine per-window done pulse.
- l0_rd  in  1  engine pooled-readout active.
- l0_tx_done  out  1  one-cycle frame-clear to engine.
- busy  out  1  high in every state except IDLE.
- win_cnt  out  AW  windows completed in current frame.
- err  out  1  sticky protocol/timeout error; cleared only on frame accept.

Behaviour:
- Reset values: state IDLE; frm_rdy=1; all pulses 0; img_addr=0; win_cnt=0; err=0; row/col counters=0.
- IDLE: frm_rdy=1. On frm_vld, clear img_addr, row, col, win_cnt and err, then go LOAD. frm_vld outside IDLE is ignored (frm_rdy=0).
- LOAD: win_ld=1 for the first cycle only. A latency counter runs WIN_LAT cycles, then the FSM goes STRT.
- STRT: if ds_rdy=1, pulse l0_strt for exactly one cycle and go WAIT. If ds_rdy=0, hold in STRT with l0_strt=0.
- WAIT: hold until l0_addr_inc=1, then go ADV with win_cnt+1.
  - l0_addr_inc arriving in any state other than WAIT sets err and is otherwise ignored.
- ADV: one cycle.
  - If col<IMG_W-K: col+1, img_addr+1.
  - Else col=0, row+1, img_addr+K, which skips the K-1 border pixels plus 1.
  - If this was the last window (row=IMG_H-K and col=IMG_W-K), go DRAIN; else go LOAD.
- DRAIN: wait for l0_rd=0 on two consecutive cycles, then go DONE.
- DONE: l0_tx_done=1 for one cycle, then go IDLE. win_cnt holds its final value until the next frame accept.
- Latency per window: 1 (LOAD) + WIN_LAT + 1 (STRT) + engine time + 1 (ADV). The engine takes 3 cycles from strt to addr_inc with K=3.
- Widths: img_addr and win_cnt wrap mod 2^AW. The default max address is 25*28+25=725 < 1024, so no wrap occurs.
- Reset mid-frame: all state returns to reset values immediately (asynchronous). No l0_tx_done is generated; the engine has its own reset.
- Simultaneous ds_rdy drop and l0_strt in STRT: the strt already issued stands; ds_rdy is sampled only in STRT.

Optional Feature:
- Macro: L0_SCHED_WDOG_EN.
- Defined: a 5-bit watchdog counts cycles in WAIT and DRAIN. On reaching 31, it sets err, pulses l0_tx_done for one cycle and returns to IDLE (frame aborted).
- Undefined: no watchdog logic; WAIT and DRAIN wait indefinitely. err is set only by stray l0_addr_inc.

Test Plan:
- Reset, then frm_vld=1 with an engine model returning l0_addr_inc 3 cycles after l0_strt -> frm_rdy drops the next cycle; first win_ld has img_addr=0.
- Run a full frame with ds_rdy=1 -> exactly 676 l0_strt pulses. img_addr sequence is 0..25, 28..53, ... up to 725. win_cnt=676. One l0_tx_done after l0_rd is low 2 cycles; then frm_rdy=1.
- Hold ds_rdy=0 for 10 cycles at window 5 -> no l0_strt during the hold. Strt is issued on the first ds_rdy=1 cycle; img_addr stays 5.
- Inject l0_addr_inc during LOAD -> err=1, sequence unaffected. The next frame accept clears err.
- Assert rst at window 100 -> all outputs return to reset values within the same cycle. A new frm_vld restarts at img_addr=0.
- With L0_SCHED_WDOG_EN, suppress l0_addr_inc -> 31 cycles after l0_strt, err=1, l0_tx_done pulses once, state IDLE, frm_rdy=1.
